// File: rtl/pipe_tx_arbiter_if.sv
// Purpose: bundles the shared ADC capture buses and the pipe FIFO write port of the tx arbiter.
// Latency: none, wiring only.
// Backpressure: fifo_full from the FIFO side stalls the arbiter, which holds its current word.
interface pipe_tx_arbiter_if #(
  parameter int N_ADC = 8,
  parameter int W_ADC = 18,
  parameter int W_OUT = 16
);
  logic [N_ADC-1:0] adc_data_valid;
  logic [W_ADC-1:0] adc_data_a;
  logic [W_ADC-1:0] adc_data_b;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [W_OUT-1:0] fifo_data;

  // Source side: ADC controllers plus the pipe FIFO full flag
  modport master (
    output adc_data_valid, adc_data_a, adc_data_b, fifo_full,
    input  fifo_wr_en, fifo_data
  );

  // Arbiter side
  modport slave (
    input  adc_data_valid, adc_data_a, adc_data_b, fifo_full,
    output fifo_wr_en, fifo_data
  );
endinterface

// File: rtl/pipe_tx_arbiter.sv
// Purpose: round-robin scheduler of per-channel ADC samples into tagged frames for the pipe FIFO.
// Latency: strobe at t -> header write at t+2, data at t+3 (t+3 timestamp, t+4 data with PIPE_ARB_TIMESTAMP_EN).
// Backpressure: fifo_full holds the FSM in place with the word stable; queued samples are overwritten newest-wins.
module pipe_tx_arbiter #(
  parameter int N_ADC = 8,
  parameter int W_ADC = 18,
  parameter int W_OUT = 16,
  parameter int W_SEQ = 8
) (
  input  logic                clk50_in,
  input  logic                rst_n_in,
  input  logic [N_ADC-1:0]    chan_en_in,
  input  logic                flush_in,
  pipe_tx_arbiter_if.slave    pif,
  output logic                busy_out,
  output logic                overrun_out,
  output logic [15:0]         overrun_cnt_out
);

  localparam int CHW  = (N_ADC > 1) ? $clog2(N_ADC) : 1;
  localparam int HALF = N_ADC / 2;

`ifdef PIPE_ARB_TIMESTAMP_EN
  localparam logic [3:0] HDR_NIB = 4'hB;
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_TS, S_DAT} state_t;
`else
  localparam logic [3:0] HDR_NIB = 4'hA;
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DAT} state_t;
`endif

  state_t             state, state_nxt;
  logic [N_ADC-1:0]   pend;
  logic [N_ADC-1:0]   cap_vld;
  logic [N_ADC-1:0]   grant_oh;
  logic [N_ADC-1:0]   ovr_ev;
  logic [W_ADC-1:0]   cap [N_ADC];
  logic [W_SEQ-1:0]   seq [N_ADC];
  logic [CHW-1:0]     rr_ptr;
  logic [CHW-1:0]     frame_ch;
  logic [CHW-1:0]     grant_ch;
  logic [CHW-1:0]     idx;
  logic               grant_any;
  logic               do_grant;
  logic               dat_done;
  logic [W_ADC-1:0]   frame_data;
  logic [16:0]        ovr_sum;

`ifdef PIPE_ARB_TIMESTAMP_EN
  logic [15:0]        ts_cnt;
  logic [15:0]        ts [N_ADC];
  logic [15:0]        frame_ts;
`endif

  function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] c);
    return (c == CHW'(N_ADC - 1)) ? '0 : c + 1'b1;
  endfunction

  assign cap_vld  = pif.adc_data_valid & chan_en_in;
  assign do_grant = (state == S_IDLE) && grant_any;
  assign dat_done = (state == S_DAT) && !pif.fifo_full;
  assign busy_out = (state != S_IDLE) || (|pend);

  // First enabled pending channel at or after rr_ptr; scanning backwards leaves the nearest one
  always_comb begin
    grant_any = 1'b0;
    grant_ch  = '0;
    idx       = '0;
    for (int k = N_ADC - 1; k >= 0; k--) begin
      idx = CHW'((int'(rr_ptr) + k) % N_ADC);
      if (pend[idx] && chan_en_in[idx]) begin
        grant_any = 1'b1;
        grant_ch  = idx;
      end
    end
  end

  // One-hot grant and overrun events (a queued sample replaced before it was granted)
  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < N_ADC; i++) begin
      grant_oh[i] = do_grant && (grant_ch == CHW'(i));
    end
    ovr_ev  = cap_vld & pend & ~grant_oh;
    ovr_sum = {1'b0, overrun_cnt_out} + 17'($countones(ovr_ev));
  end

  // Frame FSM next state and FIFO word; output word is a pure function of registered state
  always_comb begin
    state_nxt      = state;
    pif.fifo_wr_en = 1'b0;
    pif.fifo_data  = '0;
    case (state)
      S_IDLE: begin
        if (grant_any) state_nxt = S_HDR;
      end
      S_HDR: begin
        pif.fifo_wr_en = !pif.fifo_full;
        pif.fifo_data  = {HDR_NIB, 4'(frame_ch), seq[frame_ch]};
`ifdef PIPE_ARB_TIMESTAMP_EN
        if (!pif.fifo_full) state_nxt = S_TS;
      end
      S_TS: begin
        pif.fifo_wr_en = !pif.fifo_full;
        pif.fifo_data  = W_OUT'(frame_ts);
        if (!pif.fifo_full) state_nxt = S_DAT;
`else
        if (!pif.fifo_full) state_nxt = S_DAT;
`endif
      end
      S_DAT: begin
        pif.fifo_wr_en = !pif.fifo_full;
        pif.fifo_data  = frame_data[W_ADC-1 -: W_OUT];
        if (!pif.fifo_full) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any frame in flight
  always_ff @(posedge clk50_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Latch the granted channel's sample so a same-cycle recapture can queue behind it
  always_ff @(posedge clk50_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_ch   <= '0;
      frame_data <= '0;
      rr_ptr     <= '0;
`ifdef PIPE_ARB_TIMESTAMP_EN
      frame_ts   <= '0;
`endif
    end else if (do_grant) begin
      frame_ch   <= grant_ch;
      frame_data <= cap[grant_ch];
      rr_ptr     <= next_ch(grant_ch);
`ifdef PIPE_ARB_TIMESTAMP_EN
      frame_ts   <= ts[grant_ch];
`endif
    end
  end

  // Per-channel capture and pending flags; a capture beats grant, flush and disable
  always_ff @(posedge clk50_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < N_ADC; i++) begin
        pend[i] <= 1'b0;
        cap[i]  <= '0;
`ifdef PIPE_ARB_TIMESTAMP_EN
        ts[i]   <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < N_ADC; i++) begin
        if (cap_vld[i]) begin
          cap[i]  <= (i < HALF) ? pif.adc_data_a : pif.adc_data_b;
          pend[i] <= 1'b1;
`ifdef PIPE_ARB_TIMESTAMP_EN
          ts[i]   <= ts_cnt;
`endif
        end else if (flush_in || grant_oh[i] || !chan_en_in[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Sequence numbers advance only once the data word is actually written
  always_ff @(posedge clk50_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < N_ADC; i++) seq[i] <= '0;
    end else if (dat_done) begin
      seq[frame_ch] <= seq[frame_ch] + 1'b1;
    end
  end

  // Sticky overrun flag and saturating overwrite count; flush clears both
  always_ff @(posedge clk50_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      overrun_out     <= 1'b0;
      overrun_cnt_out <= '0;
    end else if (flush_in) begin
      overrun_out     <= 1'b0;
      overrun_cnt_out <= '0;
    end else if (|ovr_ev) begin
      overrun_out     <= 1'b1;
      overrun_cnt_out <= ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
    end
  end

`ifdef PIPE_ARB_TIMESTAMP_EN
  // Free-running cycle counter sampled into ts[] at capture
  always_ff @(posedge clk50_in or negedge rst_n_in) begin
    if (!rst_n_in) ts_cnt <= '0;
    else           ts_cnt <= ts_cnt + 1'b1;
  end
`endif

endmodule
